// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings for the multiply/divide unit.
//   - MDU_* : operation codes carried on the op port of mdu_hilo.
//   - S_*   : divide FSM state encodings.
//   - mdu_cnt_width(): width of the divide iteration counter for a given WIDTH.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    // One extra bit so the counter can represent WIDTH itself.
    function automatic int mdu_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mdu_hilo_div_core.sv
// div_core: iterative restoring divider datapath for mdu_hilo.
// Operates on magnitudes only; sign handling lives in the parent.
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   start_i             load dividend/divisor, clear remainder and counter
//   step_i              perform one restoring step this cycle
//   dividend_i          unsigned dividend
//   divisor_i           unsigned divisor
//   quo_o, rem_o        current quotient / partial remainder
//   last_o              the step taken this cycle is the final one
module div_core
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quo_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             last_o
);

    localparam int CW = mdu_cnt_width(WIDTH);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] trial;
    logic             trial_unused;

    // Shifted partial remainder is always below 2*divisor, so a non-negative
    // trial difference fits in WIDTH bits; bit WIDTH of trial is never needed.
    assign rem_sh       = {rem_q, quo_q[WIDTH-1]};
    assign trial        = {1'b0, rem_sh} - {2'b00, dvs_q};
    assign trial_unused = trial[WIDTH];

    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        if (start_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            dvs_d = divisor_i;
            cnt_d = '0;
        end else if (step_i) begin
            if (!trial[WIDTH+1]) begin
                rem_d = trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = rem_sh[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    assign last_o = step_i && (cnt_q == CW'(WIDTH - 1));
    assign quo_o  = quo_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: multiply/divide unit with architectural HI/LO registers (EX stage).
// Multiplies finish in one cycle; divides run WIDTH restoring steps plus a
// sign-fix cycle while holding busy so the pipeline stalls.
// Optional feature macro: MDU_DIVZERO_EN (divide by zero short-circuits and
// pulses div_zero; otherwise div_zero is tied low).
// Ports:
//   clk, resetn     clock, asynchronous active-low reset
//   op_valid, op    MDU instruction present in EX and its operation code
//   src_a, src_b    rs / rt operand values
//   cancel          flush from MEM/WB; aborts a divide, blocks accept
//   busy            divide in progress (stall request)
//   done            one-cycle pulse when a MULT/DIV result lands in HI/LO
//   div_zero        divide-by-zero pulse (MDU_DIVZERO_EN only)
//   hi, lo          HI/LO registers
//
// state  | meaning
// S_IDLE | ready to accept an operation
// S_DIV  | one restoring divide step per cycle
// S_FIX  | apply result signs and write HI/LO
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    logic             accept;
    logic             is_signed;
    logic             dz_hit;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             div_start, div_step, div_last;
    logic [WIDTH-1:0] div_quo, div_rem;

    assign busy   = (state_q != S_IDLE);
    assign accept = op_valid && !busy && !cancel;

    assign is_signed = (op == MDU_MULT) || (op == MDU_DIV);

    // Sign- or zero-extend to full product width so one multiplier serves both.
    assign ext_a = is_signed ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
    assign ext_b = is_signed ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
    assign prod  = ext_a * ext_b;

    // -2^(W-1) maps to itself, which is the correct unsigned magnitude.
    assign mag_a = (is_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    assign mag_b = (is_signed && src_b[WIDTH-1]) ? -src_b : src_b;

`ifdef MDU_DIVZERO_EN
    assign dz_hit = (src_b == '0);
`else
    assign dz_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        done_d    = 1'b0;
        div_start = 1'b0;
        div_step  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (op)
                        MDU_MULT, MDU_MULTU: begin
                            {hi_d, lo_d} = prod;
                            done_d       = 1'b1;
                        end
                        MDU_MTHI: hi_d = src_a;
                        MDU_MTLO: lo_d = src_a;
                        MDU_DIV, MDU_DIVU: begin
                            if (dz_hit) begin
                                done_d = 1'b1;
                            end else begin
                                div_start = 1'b1;
                                qneg_d    = is_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                                rneg_d    = is_signed && src_a[WIDTH-1];
                                state_d   = S_DIV;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_DIV: begin
                div_step = !cancel;
                if (cancel) begin
                    state_d = S_IDLE;
                end else if (div_last) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!cancel) begin
                    lo_d   = qneg_q ? -div_quo : div_quo;
                    hi_d   = rneg_q ? -div_rem : div_rem;
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

`ifdef MDU_DIVZERO_EN
    logic dz_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dz_q <= 1'b0;
        end else begin
            dz_q <= accept && (op == MDU_DIV || op == MDU_DIVU) && dz_hit;
        end
    end

    assign div_zero = dz_q;
`else
    assign div_zero = 1'b0;
`endif

    div_core #(
        .WIDTH (WIDTH)
    ) u_div_core (
        .clk        (clk),
        .resetn     (resetn),
        .start_i    (div_start),
        .step_i     (div_step),
        .dividend_i (mag_a),
        .divisor_i  (mag_b),
        .quo_o      (div_quo),
        .rem_o      (div_rem),
        .last_o     (div_last)
    );

    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multiply/divide unit with architectural HI/LO registers for the five-stage CPU.
- Sits in EX, parallel to the ALU.
- Its hi/lo outputs feed the EX result-select 4-way mux: ALU, HI, LO, link.
- Multiplies complete in 1 cycle; divides are iterative restoring and hold busy so the hazard logic stalls IF/ID/EX.

Parameters:
- WIDTH, 32, operand and HI/LO width; the divide iterates WIDTH times.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- op_valid  in  1  EX holds an MDU instruction.
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved/no-op.
- src_a  in  WIDTH  rs value (dividend / multiplicand / MTHI-MTLO data).
- src_b  in  WIDTH  rt value (divisor / multiplier).
- cancel  in  1  exception/flush from MEM/WB.
- busy  out  1  divide in progress; the stall request.
- done  out  1  one-cycle pulse when a MULT/DIV result lands in HI/LO.
- div_zero  out  1  divide-by-zero pulse (macro only, else tied 0).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, resetn=0):
  - hi=0, lo=0, busy=0, done=0, div_zero=0.
  - FSM to IDLE, iteration counter=0.
- Accept condition: op_valid && !busy && !cancel. op_valid while busy is ignored, because upstream is stalled and re-presents the instruction.
- MULT/MULTU, accepted at cycle T:
  - {hi,lo} is set to the 2*WIDTH-bit product (signed or unsigned) at the T edge.
  - done=1 during T+1; busy never asserts.
- MTHI/MTLO: the selected register takes src_a at the T edge; the other register is unchanged; done stays 0.
- DIV/DIVU FSM states: IDLE -> DIV -> FIX -> IDLE.
  - IDLE, on accept: latch |a|, |b| (signed ops) or raw values (unsigned). Latch quotient-sign = a[msb]^b[msb] and remainder-sign = a[msb], both signed only. Counter=0. Go to DIV.
  - DIV: one restoring step per cycle.
    - Shift {rem,quo} left by 1 and trial-subtract the divisor.
    - If no borrow: keep the difference and set quo LSB=1.
    - After WIDTH steps go to FIX.
  - FIX: negate quotient if quotient-sign is set; negate remainder if remainder-sign is set. Write lo=quotient, hi=remainder. Go to IDLE.
  - busy=1 during cycles T+1 .. T+WIDTH+1 (DIV and FIX).
  - done=1 during T+WIDTH+2, the first cycle the new hi/lo are visible.
- Overflow: -2^(W-1) / -1 gives lo=0x80000000, hi=0. No trap.
- cancel:
  - While busy: abort, HI/LO untouched, IDLE next cycle, no done.
  - Same cycle as op_valid: the op is not accepted.
  - cancel has priority over FIX completion.
- Mid-operation reset: immediate return to reset values.
- hi/lo are registered outputs only; there is no combinational bypass.

Optional Feature:
- Macro: MDU_DIVZERO_EN.
- Defined:
  - DIV/DIVU with src_b=0 does not enter DIV.
  - HI/LO are unchanged; busy stays 0.
  - div_zero=1 and done=1 during T+1.
- Undefined:
  - Divide by zero runs the full iteration with the natural restoring result: unsigned lo=all ones, hi=dividend; signed gets FIX sign correction applied.
  - div_zero is tied 0.

Decomposition:
- Package mdu_pkg:
  - op encodings: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO.
  - FSM state encodings: S_IDLE, S_DIV, S_FIX.
  - iteration counter width, $clog2(WIDTH)+1.
- Sub-module div_core holds the iterative restoring datapath (rem/quo/divisor registers, counter, step logic) with start/finish signals.
- mdu_hilo keeps the FSM, sign handling, multiply, HI/LO and cancel.

Test Plan:
- MULTU 0xFFFFFFFF*0x2 -> next cycle hi=0x00000001, lo=0xFFFFFFFE, done=1, busy=0.
- MULT 0xFFFFFFFE(-2)*0x3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIV -7/2 -> busy for 33 cycles, then lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1), done at T+34. A second op_valid presented during busy is ignored.
- DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV in progress, cancel at iteration 10 -> busy=0 next cycle, hi/lo keep their prior MTHI/MTLO-loaded values 0xA5A5A5A5/0x5A5A5A5A, no done.
- DIVU 5/0:
  - With MDU_DIVZERO_EN: div_zero=done=1 at T+1, hi/lo unchanged.
  - Without it: lo=0xFFFFFFFF, hi=5 at T+34.
  - Additionally assert resetn=0 mid-divide -> all outputs 0 asynchronously.
